// File: rtl/cu_pkg.sv
// Shared instruction-format constants, decode struct and pipeline stage records
// for the pipeline issue scheduler.
package cu_pkg;

    localparam int unsigned IW    = 16;
    localparam int unsigned RAW   = 3;
    localparam int unsigned SEL_W = 4;

    typedef enum logic [1:0] {
        OpLoad  = 2'b00,
        OpStore = 2'b01,
        OpMisc  = 2'b10,
        OpAlu   = 2'b11
    } op1_e;

    // Sub-codes carried in the Rs field when OP1 selects OpMisc
    localparam logic [2:0] Op2Li  = 3'b000;
    localparam logic [2:0] Op2Jmp = 3'b100;
    localparam logic [2:0] Op2Bcc = 3'b111;

    localparam logic [2:0] CondZ  = 3'b000;
    localparam logic [2:0] CondNz = 3'b001;
    localparam logic [2:0] CondC  = 3'b010;
    localparam logic [2:0] CondNc = 3'b011;

    typedef struct packed {
        logic             src1_vld;
        logic             src2_vld;
        logic             wr_en;
        logic             mem_rd;
        logic             mem_wr;
        logic             is_br;
        logic             is_jmp;
        logic [2:0]       cond;
        logic [SEL_W-1:0] alu_sel;
    } dec_t;

    typedef struct packed {
        logic             valid;
        logic             wr_en;
        logic             mem_rd;
        logic             mem_wr;
        logic             is_br;
        logic             is_jmp;
        logic [2:0]       cond;
        logic [SEL_W-1:0] alu_sel;
        logic [RAW-1:0]   rs;
        logic [RAW-1:0]   rd;
        logic [7:0]       tgt;
    } ex_stage_t;

    typedef struct packed {
        logic           wr_en;
        logic           mem_rd;
        logic           mem_wr;
        logic [RAW-1:0] rd;
    } mem_stage_t;

    typedef struct packed {
        logic           wr_en;
        logic [RAW-1:0] rd;
    } wb_stage_t;

    // flags = {C, Z}; unlisted condition codes are never taken
    function automatic logic cond_true(input logic [2:0] cond, input logic [1:0] flags);
        logic res;
        case (cond)
            CondZ:   res = flags[0];
            CondNz:  res = ~flags[0];
            CondC:   res = flags[1];
            CondNc:  res = ~flags[1];
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decoder: classifies an instruction into register-use, memory,
// branch and ALU-select controls.
module instr_decode
    import cu_pkg::*;
(
    input  logic [IW-1:0] instr,
    output dec_t          dec
);

    // Low immediate bits only matter to the datapath, not to control
    logic unused_low;
    assign unused_low = ^instr[3:0];

    always_comb begin
        dec = '0;
        unique case (op1_e'(instr[15:14]))
            OpAlu: begin
                dec.src1_vld = 1'b1;
                dec.src2_vld = 1'b1;
                dec.wr_en    = 1'b1;
                dec.alu_sel  = instr[7:4];
            end
            OpLoad: begin
                dec.src1_vld = 1'b1;
                dec.wr_en    = 1'b1;
                dec.mem_rd   = 1'b1;
            end
            OpStore: begin
                dec.src1_vld = 1'b1;
                dec.src2_vld = 1'b1;
                dec.mem_wr   = 1'b1;
            end
            OpMisc: begin
                case (instr[13:11])
                    Op2Li:  dec.wr_en = 1'b1;
                    Op2Jmp: begin
                        dec.is_br  = 1'b1;
                        dec.is_jmp = 1'b1;
                    end
                    Op2Bcc: begin
                        dec.is_br = 1'b1;
                        dec.cond  = instr[10:8];
                    end
                    default: ;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/pipeline_issue_scheduler.sv
// Issue scheduler: holds one instruction in ID, stalls on RAW hazards against EX/MEM,
// and resolves branches in EX with a one-cycle redirect that flushes ID.
module pipeline_issue_scheduler
    import cu_pkg::*;
(
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [IW-1:0]    IN_INSTR,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       FLAGS,
    output logic [SEL_W-1:0] S_ALU,
    output logic [RAW-1:0]   registerAddress1,
    output logic [RAW-1:0]   registerAddress2,
    output logic             EX_VALID,
    output logic             MEM_RD,
    output logic             MEM_WR,
    output logic             WB_EN,
    output logic [RAW-1:0]   WB_ADDR,
    output logic             BR_TAKEN,
    output logic [7:0]       BR_TARGET,
    output logic             STALL
);

    logic           id_valid_q, id_valid_d;
    logic [IW-1:0]  id_instr_q, id_instr_d;
    ex_stage_t      ex_q, ex_d;
    mem_stage_t     mem_q, mem_d;
    wb_stage_t      wb_q, wb_d;

    dec_t           id_dec;
    logic [RAW-1:0] id_rs, id_rd;
    logic           hazard, issue, accept, br_taken;

    assign id_rs = id_instr_q[13:11];
    assign id_rd = id_instr_q[10:8];

    instr_decode u_instr_decode (
        .instr (id_instr_q),
        .dec   (id_dec)
    );

    // WB is not compared: the register file is write-through to its read ports
    always_comb begin
        hazard = 1'b0;
        if (ex_q.wr_en && ((id_dec.src1_vld && id_rs == ex_q.rd) ||
                           (id_dec.src2_vld && id_rd == ex_q.rd))) begin
            hazard = 1'b1;
        end
        if (mem_q.wr_en && ((id_dec.src1_vld && id_rs == mem_q.rd) ||
                            (id_dec.src2_vld && id_rd == mem_q.rd))) begin
            hazard = 1'b1;
        end
    end

    assign br_taken = ex_q.is_br && (ex_q.is_jmp || cond_true(ex_q.cond, FLAGS));
    assign issue    = id_valid_q && !hazard && !br_taken;
    assign IN_READY = (!id_valid_q || issue) && !br_taken;
    assign accept   = IN_VALID && IN_READY;

    always_comb begin
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        if (accept) begin
            id_valid_d = 1'b1;
            id_instr_d = IN_INSTR;
        end else if (issue || br_taken) begin
            id_valid_d = 1'b0;
        end

        // Bubbles are all-zero so downstream strobes need no separate valid
        ex_d = '0;
        if (issue) begin
            ex_d.valid   = 1'b1;
            ex_d.wr_en   = id_dec.wr_en;
            ex_d.mem_rd  = id_dec.mem_rd;
            ex_d.mem_wr  = id_dec.mem_wr;
            ex_d.is_br   = id_dec.is_br;
            ex_d.is_jmp  = id_dec.is_jmp;
            ex_d.cond    = id_dec.cond;
            ex_d.alu_sel = id_dec.alu_sel;
            ex_d.rs      = id_rs;
            ex_d.rd      = id_rd;
            ex_d.tgt     = id_instr_q[7:0];
        end

        mem_d.wr_en  = ex_q.wr_en;
        mem_d.mem_rd = ex_q.mem_rd;
        mem_d.mem_wr = ex_q.mem_wr;
        mem_d.rd     = ex_q.rd;

        wb_d.wr_en = mem_q.wr_en;
        wb_d.rd    = mem_q.rd;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            id_valid_q <= 1'b0;
            id_instr_q <= '0;
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
        end else begin
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            ex_q       <= ex_d;
            mem_q      <= mem_d;
            wb_q       <= wb_d;
        end
    end

    assign S_ALU            = ex_q.alu_sel;
    assign registerAddress1 = ex_q.rs;
    assign registerAddress2 = ex_q.rd;
    assign EX_VALID         = ex_q.valid;
    assign MEM_RD           = mem_q.mem_rd;
    assign MEM_WR           = mem_q.mem_wr;
    assign WB_EN            = wb_q.wr_en;
    assign WB_ADDR          = wb_q.rd;
    assign BR_TAKEN         = br_taken;
    assign BR_TARGET        = br_taken ? ex_q.tgt : 8'h00;
    assign STALL            = id_valid_q && !issue;

endmodule

// File: tb/tb_pipeline_issue_scheduler.sv
// Self-checking bench: an instruction-level model of the ID/EX/MEM/WB pipe is compared
// against the scheduler every cycle, with hand-computed spot checks on directed sequences.
module tb_pipeline_issue_scheduler;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic [15:0] IN_INSTR = 16'h0000;
    logic        IN_VALID = 1'b0;
    logic [1:0]  FLAGS = 2'b00;
    logic        IN_READY, EX_VALID, MEM_RD, MEM_WR, WB_EN, BR_TAKEN, STALL;
    logic [3:0]  S_ALU;
    logic [2:0]  registerAddress1, registerAddress2, WB_ADDR;
    logic [7:0]  BR_TARGET;

    int errors = 0;
    int checks = 0;

    pipeline_issue_scheduler dut (
        .CLOCK            (CLOCK),
        .RESET            (RESET),
        .IN_INSTR         (IN_INSTR),
        .IN_VALID         (IN_VALID),
        .IN_READY         (IN_READY),
        .FLAGS            (FLAGS),
        .S_ALU            (S_ALU),
        .registerAddress1 (registerAddress1),
        .registerAddress2 (registerAddress2),
        .EX_VALID         (EX_VALID),
        .MEM_RD           (MEM_RD),
        .MEM_WR           (MEM_WR),
        .WB_EN            (WB_EN),
        .WB_ADDR          (WB_ADDR),
        .BR_TAKEN         (BR_TAKEN),
        .BR_TARGET        (BR_TARGET),
        .STALL            (STALL)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Instruction-level semantics
    function automatic bit writes(input logic [15:0] i);
        return (i[15:14] == 2'b11) || (i[15:14] == 2'b00) ||
               (i[15:14] == 2'b10 && i[13:11] == 3'b000);
    endfunction

    function automatic bit reads(input logic [15:0] i, input logic [2:0] r);
        case (i[15:14])
            2'b11, 2'b01: return (r == i[13:11]) || (r == i[10:8]);
            2'b00:        return r == i[13:11];
            default:      return 1'b0;
        endcase
    endfunction

    function automatic bit taken(input logic [15:0] i, input logic [1:0] fl);
        if (i[15:14] != 2'b10) return 1'b0;
        if (i[13:11] == 3'b100) return 1'b1;
        if (i[13:11] != 3'b111) return 1'b0;
        case (i[10:8])
            3'd0:    return fl[0];
            3'd1:    return !fl[0];
            3'd2:    return fl[1];
            3'd3:    return !fl[1];
            default: return 1'b0;
        endcase
    endfunction

    // Stage contents: 0 = ID, 1 = EX, 2 = MEM, 3 = WB
    logic [15:0] m_instr [4];
    bit          m_v     [4];
    logic [15:0] n_instr [4];
    bit          n_v     [4];

    always @(negedge CLOCK) begin
        bit haz, br, iss, rdy, st;
        haz = 1'b0;
        for (int s = 1; s <= 2; s++) begin
            if (m_v[0] && m_v[s] && writes(m_instr[s]) && reads(m_instr[0], m_instr[s][10:8]))
                haz = 1'b1;
        end
        br  = m_v[1] && taken(m_instr[1], FLAGS);
        iss = m_v[0] && !haz && !br;
        st  = m_v[0] && !iss;
        rdy = (!m_v[0] || iss) && !br;

        check("IN_READY", 16'(IN_READY), 16'(rdy));
        check("STALL", 16'(STALL), 16'(st));
        check("EX_VALID", 16'(EX_VALID), 16'(m_v[1]));
        check("S_ALU", 16'(S_ALU),
              16'((m_v[1] && m_instr[1][15:14] == 2'b11) ? m_instr[1][7:4] : 4'd0));
        check("RA1", 16'(registerAddress1), 16'(m_v[1] ? m_instr[1][13:11] : 3'd0));
        check("RA2", 16'(registerAddress2), 16'(m_v[1] ? m_instr[1][10:8] : 3'd0));
        check("MEM_RD", 16'(MEM_RD), 16'(m_v[2] && m_instr[2][15:14] == 2'b00));
        check("MEM_WR", 16'(MEM_WR), 16'(m_v[2] && m_instr[2][15:14] == 2'b01));
        check("WB_EN", 16'(WB_EN), 16'(m_v[3] && writes(m_instr[3])));
        check("WB_ADDR", 16'(WB_ADDR), 16'(m_v[3] ? m_instr[3][10:8] : 3'd0));
        check("BR_TAKEN", 16'(BR_TAKEN), 16'(br));
        check("BR_TARGET", 16'(BR_TARGET), 16'(br ? m_instr[1][7:0] : 8'h00));

        n_v[3] = m_v[2]; n_instr[3] = m_instr[2];
        n_v[2] = m_v[1]; n_instr[2] = m_instr[1];
        n_v[1] = iss;    n_instr[1] = m_instr[0];
        if (IN_VALID && rdy) begin
            n_v[0] = 1'b1; n_instr[0] = IN_INSTR;
        end else begin
            n_v[0] = m_v[0] && !iss && !br; n_instr[0] = m_instr[0];
        end
    end

    always @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            for (int k = 0; k < 4; k++) m_v[k] <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                m_v[k]     <= n_v[k];
                m_instr[k] <= n_instr[k];
            end
        end
    end

    // One cycle: drive just after the rising edge, return at the sampling (falling) edge
    task automatic drive(input bit v, input logic [15:0] ins, input logic [1:0] fl);
        @(posedge CLOCK);
        #1;
        IN_VALID = v;
        IN_INSTR = ins;
        FLAGS    = fl;
        @(negedge CLOCK);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 16'h0000, 2'b00);
    endtask

    // {valid, flags, instr}
    logic [18:0] tbl [12] = '{
        {1'b1, 2'b00, 16'h8300}, {1'b1, 2'b00, 16'hDB10}, {1'b1, 2'b00, 16'h9000},
        {1'b1, 2'b00, 16'h0500}, {1'b1, 2'b00, 16'h4D00}, {1'b1, 2'b00, 16'hBB40},
        {1'b1, 2'b00, 16'hC120}, {1'b0, 2'b00, 16'h0000}, {1'b1, 2'b10, 16'hBA22},
        {1'b1, 2'b10, 16'hE550}, {1'b1, 2'b01, 16'hB933}, {1'b1, 2'b01, 16'hF7F0}
    };

    initial begin
        repeat (2) @(negedge CLOCK);
        @(posedge CLOCK);
        #1;
        RESET = 1'b1;
        @(negedge CLOCK);
        check("ready after reset", 16'(IN_READY), 16'd1);
        check("ex_valid after reset", 16'(EX_VALID), 16'd0);

        // Independent ALU ops back to back
        drive(1'b1, 16'hC120, 2'b00);
        drive(1'b1, 16'hD340, 2'b00);
        check("indep stall", 16'(STALL), 16'd0);
        drive(1'b0, 16'h0000, 2'b00);
        check("indep S_ALU first", 16'(S_ALU), 16'd2);
        drive(1'b0, 16'h0000, 2'b00);
        check("indep S_ALU second", 16'(S_ALU), 16'd4);
        drive(1'b0, 16'h0000, 2'b00);
        check("indep WB_EN first", 16'(WB_EN), 16'd1);
        check("indep WB_ADDR first", 16'(WB_ADDR), 16'd1);
        drive(1'b0, 16'h0000, 2'b00);
        check("indep WB_ADDR second", 16'(WB_ADDR), 16'd3);
        idle(3);

        // RAW on R1 with a held, independent follower under backpressure
        drive(1'b1, 16'hC120, 2'b00);
        drive(1'b1, 16'hCA30, 2'b00);
        drive(1'b1, 16'hE550, 2'b00);
        check("raw stall 1", 16'(STALL), 16'd1);
        check("raw ready 1", 16'(IN_READY), 16'd0);
        drive(1'b1, 16'hE550, 2'b00);
        check("raw stall 2", 16'(STALL), 16'd1);
        check("raw ready 2", 16'(IN_READY), 16'd0);
        drive(1'b1, 16'hE550, 2'b00);
        check("raw stall released", 16'(STALL), 16'd0);
        check("raw ready released", 16'(IN_READY), 16'd1);
        check("raw writer in WB", 16'(WB_ADDR), 16'd1);
        drive(1'b0, 16'h0000, 2'b00);
        check("raw consumer S_ALU", 16'(S_ALU), 16'd3);
        drive(1'b0, 16'h0000, 2'b00);
        check("held instr S_ALU", 16'(S_ALU), 16'd5);
        idle(4);

        // Load R2 then store using R2
        drive(1'b1, 16'h0204, 2'b00);
        drive(1'b1, 16'h5A08, 2'b00);
        drive(1'b0, 16'h0000, 2'b00);
        check("ldst stall 1", 16'(STALL), 16'd1);
        drive(1'b0, 16'h0000, 2'b00);
        check("ldst stall 2", 16'(STALL), 16'd1);
        check("ldst MEM_RD", 16'(MEM_RD), 16'd1);
        drive(1'b0, 16'h0000, 2'b00);
        check("ldst stall released", 16'(STALL), 16'd0);
        check("ldst load WB_ADDR", 16'(WB_ADDR), 16'd2);
        drive(1'b0, 16'h0000, 2'b00);
        check("store RA1", 16'(registerAddress1), 16'd3);
        check("store RA2", 16'(registerAddress2), 16'd2);
        drive(1'b0, 16'h0000, 2'b00);
        check("ldst MEM_WR", 16'(MEM_WR), 16'd1);
        idle(3);

        // Conditional branch on Z, taken
        drive(1'b1, 16'hB85C, 2'b00);
        drive(1'b1, 16'hC120, 2'b00);
        drive(1'b1, 16'hD340, 2'b01);
        check("bz taken", 16'(BR_TAKEN), 16'd1);
        check("bz target", 16'(BR_TARGET), 16'h5C);
        check("bz ready", 16'(IN_READY), 16'd0);
        drive(1'b0, 16'h0000, 2'b01);
        check("bz pulse ends", 16'(BR_TAKEN), 16'd0);
        check("bz flushed", 16'(EX_VALID), 16'd0);
        idle(3);

        // Same branch with Z clear: no redirect, follower issues
        drive(1'b1, 16'hB85C, 2'b00);
        drive(1'b1, 16'hC120, 2'b00);
        drive(1'b0, 16'h0000, 2'b00);
        check("bz not taken", 16'(BR_TAKEN), 16'd0);
        check("bz nt stall", 16'(STALL), 16'd0);
        drive(1'b0, 16'h0000, 2'b00);
        check("bz nt follower", 16'(S_ALU), 16'd2);
        idle(4);

        // Unconditional jump
        drive(1'b1, 16'hA07E, 2'b00);
        drive(1'b0, 16'h0000, 2'b00);
        drive(1'b0, 16'h0000, 2'b00);
        check("jmp taken", 16'(BR_TAKEN), 16'd1);
        check("jmp target", 16'(BR_TARGET), 16'h7E);
        idle(3);

        // Mixed stream, checked by the model only
        for (int i = 0; i < 12; i++) begin
            logic [18:0] e;
            e = tbl[i];
            drive(e[18], e[15:0], e[17:16]);
        end
        idle(5);

        // Reset in the middle of a full pipe
        drive(1'b1, 16'hC120, 2'b00);
        drive(1'b1, 16'h0204, 2'b00);
        drive(1'b1, 16'hE550, 2'b00);
        @(posedge CLOCK);
        #3;
        RESET    = 1'b0;
        IN_VALID = 1'b0;
        @(negedge CLOCK);
        check("rst WB_EN", 16'(WB_EN), 16'd0);
        check("rst MEM_RD", 16'(MEM_RD), 16'd0);
        check("rst EX_VALID", 16'(EX_VALID), 16'd0);
        @(posedge CLOCK);
        #1;
        RESET = 1'b1;
        @(negedge CLOCK);
        check("rst release ready", 16'(IN_READY), 16'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h0000, 2'b00);
            check("rst no WB_EN", 16'(WB_EN), 16'd0);
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
